iomem_initiator: RTL and testbench
==================================

# iomem_initiator

Bus-master end of the iomem interface: accepts single read/write commands on a valid/ready command port, drives the iomem request signals (`iomem_valid`/`addr`/`wdata`/`wstrb`) and waits for `iomem_ready`, then returns read data and a status on a valid/ready response port. It lets test logic or a host bridge exercise iomem responders, such as the GPIO peripheral at `0x03xx_xxxx`, without a CPU. One transaction is outstanding at a time, and a timeout aborts accesses to absent responders.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum bus cycles to wait for `iomem_ready`; 0 disables the timeout.
- `ERR_RDATA`, default `32'hDEAD_BEEF`: `rsp_rdata` value returned on timeout.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `resetn` input 1: reset, asynchronous assert, active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command accepted when both high.
- `cmd_write` input 1: 1 = write, 0 = read.
- `cmd_addr` input 32: byte address; bits [1:0] are ignored.
- `cmd_wdata` input 32: write data.
- `cmd_wstrb` input 4: byte enables for writes.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed when both high.
- `rsp_rdata` output 32: read data (writes: data returned by the responder; timeout: `ERR_RDATA`).
- `rsp_timeout` output 1: transaction aborted by timeout.
- `iomem_valid` output 1: request valid.
- `iomem_ready` input 1: responder completion strobe.
- `iomem_wstrb` output 4: byte strobes; `4'b0000` = read.
- `iomem_addr` output 32: word-aligned address.
- `iomem_wdata` output 32: write data.
- `iomem_rdata` input 32: read data, valid while `iomem_ready` is high.

## Operation
- FSM states are IDLE, BUS and RESP. Reset enters IDLE.
- IDLE:
  - `cmd_ready` = 1, driven combinationally from state.
  - On `cmd_valid` the block registers `iomem_addr` = {`cmd_addr`[31:2], 2'b00} and `iomem_wdata`.
  - It registers `iomem_wstrb` = `cmd_write` ? `cmd_wstrb` : 0.
  - It sets `iomem_valid` = 1, clears the timeout counter and enters BUS.
  - A write with `cmd_wstrb` = 0 is issued as a read.
- BUS:
  - `iomem_valid`, addr, wdata and wstrb are held stable.
  - On an edge with `iomem_ready` = 1: clear `iomem_valid`, capture `iomem_rdata` into `rsp_rdata`, set `rsp_timeout` = 0 and `rsp_valid` = 1, then enter RESP.
  - Otherwise the counter increments.
  - If the counter = `TIMEOUT_CYCLES`−1 and `iomem_ready` = 0 (and `TIMEOUT_CYCLES` ≠ 0): clear `iomem_valid`, set `rsp_rdata` = `ERR_RDATA`, `rsp_timeout` = 1 and `rsp_valid` = 1, then enter RESP.
  - If ready and timeout coincide, ready wins.
- RESP:
  - Hold all rsp outputs.
  - On `rsp_ready` = 1: clear `rsp_valid` and enter IDLE.
  - A new command cannot be accepted in the same cycle.
- `iomem_ready` arriving outside BUS is ignored. This covers a late strobe after a timeout, and the strobe in the cycle after completion.
- Timeout counter width is $clog2(`TIMEOUT_CYCLES`+1), minimum 1 bit.
- Async reset mid-transaction:
  - `iomem_valid` and `rsp_valid` drop immediately.
  - The in-flight transaction is discarded with no response.

## Timing
- Reset values:
  - `cmd_ready` = 1 (IDLE).
  - `iomem_valid` = 0, `iomem_wstrb` = 0, `iomem_addr` = 0, `iomem_wdata` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_timeout` = 0.
- Command accepted at edge E0 → `iomem_valid` high after E0.
- `iomem_ready` sampled at edge Ek → `iomem_valid` low and `rsp_valid` high after Ek.
- With a registered responder that raises ready one edge after seeing valid: accept→response is 2 cycles.
- `iomem_valid` never deasserts before ready or timeout, and the request fields never change while it is high.
- Timeout abort happens at the `TIMEOUT_CYCLES`-th BUS edge without ready. `iomem_valid` is high for exactly `TIMEOUT_CYCLES` cycles.
- Throughput: at most one transaction per 3 cycles (IDLE→BUS→RESP).

## Structure
- Shared package `iomem_pkg`:
  - `iomem_state_e` (IDLE, BUS, RESP).
  - `IOMEM_GPIO_BASE` = 8'h03 (address bits [31:24]).
  - `IOMEM_ERR_RDATA` default constant.
- Single module, no sub-module. The timeout counter is inline.

## Test plan
- Write 0x0300_0000, wdata 0x0000_00A5, wstrb 4'b0001 to the GPIO responder. Response: timeout = 0. A following read returns 0x0000_00A5, and `leds` = 0xA5.
- Partial strobes: write 0x1122_3344 with wstrb 4'b1010 over gpio = 0. Readback = 0x1100_3300.
- Read of unmapped address 0x0400_0000 with `TIMEOUT_CYCLES` = 8. `iomem_valid` is high for exactly 8 cycles. Response: rdata 0xDEAD_BEEF, timeout = 1. A ready injected 2 cycles later is ignored and no second response appears.
- Backpressure: hold `rsp_ready` = 0 for 10 cycles. `rsp_valid` and `rsp_rdata` stay stable, `cmd_ready` = 0, and no new `iomem_valid` is issued.
- Ready on the final timeout edge: response has timeout = 0 and carries `iomem_rdata`.
- Assert `resetn` = 0 mid-BUS. `iomem_valid` drops asynchronously. After release: IDLE, `cmd_ready` = 1, no spurious `rsp_valid`.

Source files
------------

// File: rtl/iomem_pkg.sv
// Shared iomem definitions: initiator FSM states, address map and error data.
package iomem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } iomem_state_e;

  // Address bits [31:24] that select the GPIO responder
  localparam logic [7:0]  IOMEM_GPIO_BASE = 8'h03;

  // Read data returned when an access is aborted by the timeout
  localparam logic [31:0] IOMEM_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/iomem_initiator.sv
// iomem bus master: one command in, one bus access, one response out,
// with an optional timeout so accesses to absent responders still complete.
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = IOMEM_ERR_RDATA
) (
  input  logic        clk,
  input  logic        resetn,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  // iomem bus
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  // A disabled timeout still gets a 1-bit counter so the logic stays legal
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LAST_IDX = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_IDX);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  iomem_state_e     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_iomem_valid;
  logic [3:0]       r_iomem_wstrb;
  logic [31:0]      r_iomem_addr;
  logic [31:0]      r_iomem_wdata;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_timeout;

  // Byte-offset bits of the command address do not reach the bus
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^cmd_addr[1:0];

  // Command acceptance is a pure function of the state
  always_comb begin
    cmd_ready = (r_state == IDLE);
  end

  // Transaction FSM with all bus and response outputs registered
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_iomem_valid <= 1'b0;
      r_iomem_wstrb <= '0;
      r_iomem_addr  <= '0;
      r_iomem_wdata <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_iomem_addr  <= {cmd_addr[31:2], 2'b00};
            r_iomem_wdata <= cmd_wdata;
            // an all-zero strobe is a read on iomem, so zero-strobe writes become reads
            r_iomem_wstrb <= cmd_write ? cmd_wstrb : 4'b0000;
            r_iomem_valid <= 1'b1;
            r_cnt         <= '0;
            r_state       <= BUS;
          end
        end
        BUS: begin
          // ready takes priority over a timeout on the same edge
          if (iomem_ready) begin
            r_iomem_valid <= 1'b0;
            r_rsp_rdata   <= iomem_rdata;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else if (TO_EN && (r_cnt == CNT_LAST)) begin
            r_iomem_valid <= 1'b0;
            r_rsp_rdata   <= ERR_RDATA;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign iomem_valid = r_iomem_valid;
  assign iomem_wstrb = r_iomem_wstrb;
  assign iomem_addr  = r_iomem_addr;
  assign iomem_wdata = r_iomem_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_iomem_initiator.sv
// Self-checking bench for iomem_initiator: a GPIO-like responder on the bus,
// a transaction-level model of when each output must be active, and a
// per-cycle compare of the DUT against that model.
module tb_iomem_initiator;
  import iomem_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata = '0;

  iomem_initiator #(
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (IOMEM_ERR_RDATA)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transaction model: accepted at edge m_a, request on the bus for m_n
  // cycles, response held until the consuming edge m_c.
  bit          m_active = 1'b0;
  bit          m_in_reset = 1'b1;
  int          m_a = 0;
  int          m_n = 0;
  int          m_c = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic [31:0] m_rd = '0;
  logic        m_rto = 1'b0;
  logic [31:0] m_gpio = '0;

  // Responder state
  logic [31:0] leds = '0;
  bit          r_present = 1'b0;
  int          r_lat = 0;
  int          r_k = 0;
  int          stray_cyc = -100;
  int          vcnt = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // GPIO-like responder: acks lat cycles after seeing valid; can inject a stray ready
  always @(negedge clk) begin
    if (iomem_valid && r_present && r_k == r_lat && iomem_addr[31:24] == IOMEM_GPIO_BASE) begin
      if (iomem_wstrb != 4'b0000) leds = merge(leds, iomem_wdata, iomem_wstrb);
      iomem_ready = 1'b1;
      iomem_rdata = leds;
    end else if (cyc == stray_cyc) begin
      iomem_ready = 1'b1;
      iomem_rdata = 32'h5A5A_5A5A;
    end else begin
      iomem_ready = 1'b0;
      iomem_rdata = $urandom;
    end
    if (iomem_valid) r_k++;
    else r_k = 0;
  end

  // Per-cycle compare against the transaction model
  always @(negedge clk) begin
    bit pv, pr;
    #1;
    if (iomem_valid) vcnt++;
    if (!m_in_reset) begin
      pv = m_active && cyc >= m_a && cyc < m_a + m_n;
      pr = m_active && cyc >= m_a + m_n && cyc < m_c;
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, !(pv || pr)});
      chk("iomem_valid", {31'b0, iomem_valid}, {31'b0, pv});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, pr});
      if (pv) begin
        chk("iomem_addr", iomem_addr, m_addr);
        chk("iomem_wdata", iomem_wdata, m_wdata);
        chk("iomem_wstrb", {28'b0, iomem_wstrb}, {28'b0, m_wstrb});
      end
      if (pr) begin
        chk("rsp_rdata", rsp_rdata, m_rd);
        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, m_rto});
      end
    end
  end

  // One transaction; lat < 0 means no responder. Returns the DUT's response.
  task automatic do_txn(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int lat, input int bp, input bit hold,
                        input int stray_off, output logic [31:0] got_rd, output logic got_to);
    bit present, ok, wr;
    @(negedge clk);
    present = (addr[31:24] == IOMEM_GPIO_BASE) && (lat >= 0);
    ok      = present && (lat + 1 <= TO);
    wr      = w && (ws != 4'b0000);
    r_present = present;
    r_lat     = lat;
    m_addr  = {addr[31:2], 2'b00};
    m_wdata = wd;
    m_wstrb = w ? ws : 4'b0000;
    m_n     = ok ? lat + 1 : TO;
    m_rto   = !ok;
    m_rd    = !ok ? IOMEM_ERR_RDATA : (wr ? merge(m_gpio, wd, ws) : m_gpio);
    m_a     = cyc + 1;
    m_c     = m_a + m_n + bp + 1;
    m_active = 1'b1;
    if (stray_off >= 0) stray_cyc = m_a + m_n + stray_off;
    vcnt = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wstrb = ws;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    while (cyc < m_a + m_n + bp) begin
      if (hold) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_wstrb = 4'hF;
      end
      @(negedge clk);
    end
    got_rd = rsp_rdata;
    got_to = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    if (ok && wr) m_gpio = merge(m_gpio, wd, ws);
    m_active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        to;
    int          vc;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_iomem_valid", {31'b0, iomem_valid}, 32'd0);
    chk("rst_iomem_wstrb", {28'b0, iomem_wstrb}, 32'd0);
    chk("rst_iomem_addr", iomem_addr, 32'd0);
    chk("rst_iomem_wdata", iomem_wdata, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    m_in_reset = 1'b0;

    // GPIO write then readback
    do_txn(1'b1, 32'h0300_0000, 32'h0000_00A5, 4'b0001, 0, 0, 1'b0, -1, rd, to);
    chk("gpio_wr_timeout", {31'b0, to}, 32'd0);
    do_txn(1'b0, 32'h0300_0000, 32'h0, 4'b0000, 1, 0, 1'b0, -1, rd, to);
    chk("gpio_rd_data", rd, 32'h0000_00A5);
    chk("gpio_leds", leds, 32'h0000_00A5);

    // Partial strobes over a cleared register
    do_txn(1'b1, 32'h0300_0000, 32'h0, 4'b1111, 0, 0, 1'b0, -1, rd, to);
    do_txn(1'b1, 32'h0300_0002, 32'h1122_3344, 4'b1010, 2, 1, 1'b0, -1, rd, to);
    do_txn(1'b0, 32'h0300_0000, 32'h0, 4'b0000, 0, 0, 1'b0, -1, rd, to);
    chk("partial_rd_data", rd, 32'h1100_3300);

    // Unmapped read times out; stray ready two cycles later must be ignored
    do_txn(1'b0, 32'h0400_0000, 32'h0, 4'b0000, -1, 5, 1'b0, 2, rd, to);
    vc = vcnt;
    chk("to_rdata", rd, 32'hDEAD_BEEF);
    chk("to_flag", {31'b0, to}, 32'd1);
    chk("to_valid_cycles", vc, 32'd8);
    stray_cyc = cyc + 2;
    repeat (5) @(negedge clk);

    // Backpressure with a pending command held high through the response
    do_txn(1'b0, 32'h0300_0004, 32'h0, 4'b0000, 2, 10, 1'b1, -1, rd, to);
    chk("bp_rd_data", rd, 32'h1100_3300);

    // Ready on the last edge before timeout wins
    do_txn(1'b0, 32'h0300_0000, 32'h0, 4'b0000, TO - 1, 0, 1'b0, -1, rd, to);
    chk("edge_timeout", {31'b0, to}, 32'd0);
    chk("edge_rdata", rd, 32'h1100_3300);

    // Asynchronous reset in the middle of a bus access
    m_in_reset = 1'b1;
    @(negedge clk);
    r_present = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0400_0010;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_bus_valid", {31'b0, iomem_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_iomem_valid", {31'b0, iomem_valid}, 32'd0);
    chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("arst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    m_in_reset = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int          lat;
      a = $urandom;
      if ($urandom_range(0, 9) < 7) a[31:24] = IOMEM_GPIO_BASE;
      else a[31:24] = 8'h04;
      lat = int'($urandom_range(0, 9));
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), lat,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, rd, to);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
